// File: rtl/router_fsm_np.sv
// Control FSM for a 1xN packet router: decodes the header address, selects one of
// N_PORTS output FIFOs and sequences header/payload/parity loading with stall handling.
module router_fsm_np #(
    parameter int N_PORTS      = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pkt_valid,
    input  logic [ADDR_W-1:0]  data_in,
    input  logic [N_PORTS-1:0] fifo_full,
    input  logic [N_PORTS-1:0] fifo_empty,
    input  logic [N_PORTS-1:0] soft_reset,
    input  logic               parity_done,
    input  logic               low_pkt_valid,
    output logic               detect_add,
    output logic               lfd_state,
    output logic               ld_state,
    output logic               full_state,
    output logic               laf_state,
    output logic               rst_int_reg,
    output logic               drop_state,
    output logic               write_enb_reg,
    output logic               busy,
    output logic [N_PORTS-1:0] dest_sel,
    output logic               timeout_err,
    output logic               addr_err
);

    // Source handshake: a byte is consumed in every cycle where pkt_valid is high
    // and busy is low; while busy is high the source must hold its current byte.

    localparam int               CNT_W    = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [ADDR_W:0]  N_LIM    = (ADDR_W + 1)'(N_PORTS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

    typedef enum logic [3:0] {
        ST_DECODE = 4'd0,
        ST_LFD    = 4'd1,
        ST_LD     = 4'd2,
        ST_LP     = 4'd3,
        ST_FFS    = 4'd4,
        ST_LAF    = 4'd5,
        ST_WTE    = 4'd6,
        ST_CPE    = 4'd7,
        ST_DROP   = 4'd8
    } state_t;

    state_t             state, state_next;
    logic [N_PORTS-1:0] dest_q, dest_next, addr_onehot;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_next;
    logic               addr_bad, addr_empty, dest_full, dest_empty, soft_hit;
    logic               timeout_hit, addr_hit;
    logic               timeout_q, addr_q;

    always_comb begin
        addr_onehot = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            addr_onehot[i] = (data_in == ADDR_W'(i));
        end
    end

    // Destination flags are looked up through the one-hot latch, so ports that
    // are not selected can never influence the sequence.
    assign addr_bad   = ({1'b0, data_in} >= N_LIM);
    assign addr_empty = |(fifo_empty & addr_onehot);
    assign dest_full  = |(fifo_full & dest_q);
    assign dest_empty = |(fifo_empty & dest_q);
    assign soft_hit   = (state != ST_DECODE) && |(soft_reset & dest_q);

    always_comb begin
        state_next    = state;
        dest_next     = dest_q;
        wait_cnt_next = wait_cnt;
        timeout_hit   = 1'b0;
        addr_hit      = 1'b0;
        case (state)
            ST_DECODE: begin
                if (pkt_valid) begin
                    if (addr_bad) begin
                        state_next = ST_DROP;
                        addr_hit   = 1'b1;
                    end else begin
                        dest_next = addr_onehot;
                        if (addr_empty) begin
                            state_next = ST_LFD;
                        end else begin
                            state_next    = ST_WTE;
                            wait_cnt_next = '0;
                        end
                    end
                end
            end
            ST_LFD: state_next = ST_LD;
            ST_LD: begin
                if (dest_full) begin
                    state_next = ST_FFS;
                end else if (!pkt_valid) begin
                    state_next = ST_LP;
                end
            end
            ST_LP: state_next = ST_CPE;
            ST_FFS: begin
                if (!dest_full) begin
                    state_next = ST_LAF;
                end
            end
            ST_LAF: begin
                if (parity_done) begin
                    state_next = ST_DECODE;
                    dest_next  = '0;
                end else if (low_pkt_valid) begin
                    state_next = ST_LP;
                end else begin
                    state_next = ST_LD;
                end
            end
            ST_CPE: begin
                if (dest_full) begin
                    state_next = ST_FFS;
                end else begin
                    state_next = ST_DECODE;
                    dest_next  = '0;
                end
            end
            ST_WTE: begin
                // Emptying on the last allowed cycle still rescues the packet.
                if (dest_empty) begin
                    state_next = ST_LFD;
                end else if (wait_cnt == CNT_LAST) begin
                    state_next  = ST_DROP;
                    timeout_hit = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + CNT_W'(1);
                end
            end
            ST_DROP: begin
                if (!pkt_valid) begin
                    state_next = ST_DECODE;
                    dest_next  = '0;
                end
            end
            default: begin
                state_next = ST_DECODE;
                dest_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || soft_hit) begin
            state     <= ST_DECODE;
            dest_q    <= '0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
            addr_q    <= 1'b0;
        end else begin
            state     <= state_next;
            dest_q    <= dest_next;
            wait_cnt  <= wait_cnt_next;
            timeout_q <= timeout_hit;
            addr_q    <= addr_hit;
        end
    end

    assign detect_add    = (state == ST_DECODE);
    assign lfd_state     = (state == ST_LFD);
    assign ld_state      = (state == ST_LD);
    assign full_state    = (state == ST_FFS);
    assign laf_state     = (state == ST_LAF);
    assign rst_int_reg   = (state == ST_CPE);
    assign drop_state    = (state == ST_DROP);
    assign write_enb_reg = (state == ST_LD) || (state == ST_LP) || (state == ST_LAF);
    assign busy          = (state == ST_LFD) || (state == ST_LP) || (state == ST_FFS) ||
                           (state == ST_LAF) || (state == ST_WTE) || (state == ST_CPE);
    assign dest_sel      = dest_q;
    assign timeout_err   = timeout_q;
    assign addr_err      = addr_q;

endmodule

// File: tb/tb_router_fsm_np.sv
// Directed bench for router_fsm_np (N_PORTS=3, ADDR_W=2, WAIT_TIMEOUT=4): each
// scenario task drives inputs just after a rising edge and checks the decoded state.
module tb_router_fsm_np;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic [2:0] fifo_full, fifo_empty, soft_reset;
    logic       parity_done, low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, full_state, laf_state;
    logic       rst_int_reg, drop_state, write_enb_reg, busy;
    logic [2:0] dest_sel;
    logic       timeout_err, addr_err;

    int compared = 0;
    int failed   = 0;

    // {detect_add, lfd, ld, full, laf, rst_int_reg, drop, write_enb_reg, busy}
    localparam logic [8:0] F_DA   = 9'b100000000;
    localparam logic [8:0] F_LFD  = 9'b010000001;
    localparam logic [8:0] F_LD   = 9'b001000010;
    localparam logic [8:0] F_LP   = 9'b000000011;
    localparam logic [8:0] F_FFS  = 9'b000100001;
    localparam logic [8:0] F_LAF  = 9'b000010011;
    localparam logic [8:0] F_WTE  = 9'b000000001;
    localparam logic [8:0] F_CPE  = 9'b000001001;
    localparam logic [8:0] F_DROP = 9'b000000100;

    logic [13:0] obs, exp_v;
    assign obs = {detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
                  drop_state, write_enb_reg, busy, dest_sel, timeout_err, addr_err};

    router_fsm_np #(.N_PORTS(3), .ADDR_W(2), .WAIT_TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .full_state(full_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
        .drop_state(drop_state), .write_enb_reg(write_enb_reg), .busy(busy),
        .dest_sel(dest_sel), .timeout_err(timeout_err), .addr_err(addr_err)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0;
        fifo_full = 3'b000; fifo_empty = 3'b111; soft_reset = 3'b000;
        parity_done = 1'b0; low_pkt_valid = 1'b0;
        tick; tick;
        exp_v = {F_DA, 3'b000, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL reset_state got=%b want=%b", obs, exp_v); end
        reset = 1'b0;
        tick;
        exp_v = {F_DA, 3'b000, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL reset_idle got=%b want=%b", obs, exp_v); end
    endtask

    task automatic test_basic;
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b111; fifo_full = 3'b000;
        tick;
        exp_v = {F_LFD, 3'b100, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL basic_lfd got=%b want=%b", obs, exp_v); end
        tick;
        for (int i = 1; i <= 4; i++) begin
            exp_v = {F_LD, 3'b100, 2'b00}; compared++;
            if (obs !== exp_v) begin failed++; $display("FAIL basic_ld%0d got=%b want=%b", i, obs, exp_v); end
            if (i == 4) pkt_valid = 1'b0;
            tick;
        end
        exp_v = {F_LP, 3'b100, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL basic_lp got=%b want=%b", obs, exp_v); end
        tick;
        exp_v = {F_CPE, 3'b100, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL basic_cpe got=%b want=%b", obs, exp_v); end
        tick;
        exp_v = {F_DA, 3'b000, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL basic_done got=%b want=%b", obs, exp_v); end
        tick;
        exp_v = {F_DA, 3'b000, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL basic_idle got=%b want=%b", obs, exp_v); end
    endtask

    task automatic test_full_stall;
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b111;
        tick;
        exp_v = {F_LFD, 3'b010, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL full_lfd got=%b want=%b", obs, exp_v); end
        tick;
        exp_v = {F_LD, 3'b010, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL full_ld got=%b want=%b", obs, exp_v); end
        fifo_full = 3'b010;
        tick;
        for (int i = 1; i <= 3; i++) begin
            exp_v = {F_FFS, 3'b010, 2'b00}; compared++;
            if (obs !== exp_v) begin failed++; $display("FAIL full_ffs%0d got=%b want=%b", i, obs, exp_v); end
            fifo_full = (i == 1) ? 3'b011 : (i == 2) ? 3'b010 : 3'b001;
            tick;
        end
        exp_v = {F_LAF, 3'b010, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL full_laf got=%b want=%b", obs, exp_v); end
        pkt_valid = 1'b0; low_pkt_valid = 1'b1;
        tick;
        exp_v = {F_LP, 3'b010, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL full_lp got=%b want=%b", obs, exp_v); end
        low_pkt_valid = 1'b0;
        tick;
        exp_v = {F_CPE, 3'b010, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL full_cpe got=%b want=%b", obs, exp_v); end
        tick;
        exp_v = {F_DA, 3'b000, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL full_done got=%b want=%b", obs, exp_v); end
        fifo_full = 3'b000;
    endtask

    task automatic test_laf_paths;
        pkt_valid = 1'b1; data_in = 2'd0;
        tick; tick;
        fifo_full = 3'b001;
        tick;
        exp_v = {F_FFS, 3'b001, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL laf_ffs got=%b want=%b", obs, exp_v); end
        fifo_full = 3'b000;
        tick; tick;
        exp_v = {F_LD, 3'b001, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL laf_to_ld got=%b want=%b", obs, exp_v); end
        fifo_full = 3'b001;
        tick;
        fifo_full = 3'b000;
        tick;
        exp_v = {F_LAF, 3'b001, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL laf_again got=%b want=%b", obs, exp_v); end
        parity_done = 1'b1; pkt_valid = 1'b0;
        tick;
        exp_v = {F_DA, 3'b000, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL laf_parity_done got=%b want=%b", obs, exp_v); end
        parity_done = 1'b0;
    endtask

    task automatic test_wait_timeout;
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b101;
        tick;
        for (int k = 1; k <= 4; k++) begin
            exp_v = {F_WTE, 3'b010, 2'b00}; compared++;
            if (obs !== exp_v) begin failed++; $display("FAIL to_wait%0d got=%b want=%b", k, obs, exp_v); end
            tick;
        end
        exp_v = {F_DROP, 3'b010, 2'b10}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL to_drop_pulse got=%b want=%b", obs, exp_v); end
        tick;
        exp_v = {F_DROP, 3'b010, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL to_drop_hold got=%b want=%b", obs, exp_v); end
        pkt_valid = 1'b0;
        tick;
        exp_v = {F_DA, 3'b000, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL to_exit got=%b want=%b", obs, exp_v); end
        fifo_empty = 3'b111;
    endtask

    task automatic test_wait_empty;
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b101;
        tick;
        for (int k = 1; k <= 4; k++) begin
            exp_v = {F_WTE, 3'b010, 2'b00}; compared++;
            if (obs !== exp_v) begin failed++; $display("FAIL we_wait%0d got=%b want=%b", k, obs, exp_v); end
            if (k == 4) fifo_empty = 3'b111;
            tick;
        end
        exp_v = {F_LFD, 3'b010, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL we_lfd got=%b want=%b", obs, exp_v); end
        pkt_valid = 1'b0;
        tick;
        exp_v = {F_LD, 3'b010, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL we_ld got=%b want=%b", obs, exp_v); end
        tick; tick; tick;
        exp_v = {F_DA, 3'b000, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL we_done got=%b want=%b", obs, exp_v); end
    endtask

    task automatic test_addr_err;
        pkt_valid = 1'b1; data_in = 2'd3;
        tick;
        exp_v = {F_DROP, 3'b000, 2'b01}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL ae_drop_pulse got=%b want=%b", obs, exp_v); end
        tick;
        exp_v = {F_DROP, 3'b000, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL ae_drop_hold got=%b want=%b", obs, exp_v); end
        pkt_valid = 1'b0;
        tick;
        exp_v = {F_DA, 3'b000, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL ae_exit got=%b want=%b", obs, exp_v); end
        tick;
        exp_v = {F_DA, 3'b000, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL ae_parity_ignored got=%b want=%b", obs, exp_v); end
    endtask

    task automatic test_soft_reset;
        soft_reset = 3'b001; pkt_valid = 1'b1; data_in = 2'd0;
        tick;
        exp_v = {F_LFD, 3'b001, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL sr_decode_ignored got=%b want=%b", obs, exp_v); end
        soft_reset = 3'b000;
        tick;
        soft_reset = 3'b100;
        tick;
        exp_v = {F_LD, 3'b001, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL sr_other_port got=%b want=%b", obs, exp_v); end
        soft_reset = 3'b001;
        tick;
        exp_v = {F_DA, 3'b000, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL sr_own_port got=%b want=%b", obs, exp_v); end
        soft_reset = 3'b000;
        tick; tick;
        fifo_full = 3'b001;
        tick;
        exp_v = {F_FFS, 3'b001, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL sr_ffs got=%b want=%b", obs, exp_v); end
        reset = 1'b1;
        tick;
        exp_v = {F_DA, 3'b000, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL sr_reset_in_ffs got=%b want=%b", obs, exp_v); end
        data_in = 2'd3;
        tick;
        exp_v = {F_DA, 3'b000, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL sr_reset_no_pulse got=%b want=%b", obs, exp_v); end
        reset = 1'b0; pkt_valid = 1'b0; fifo_full = 3'b000;
        tick;
    endtask

    task automatic test_back_to_back;
        pkt_valid = 1'b1; data_in = 2'd0;
        tick;
        pkt_valid = 1'b0;
        tick; tick;
        exp_v = {F_LP, 3'b001, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL b2b_lp got=%b want=%b", obs, exp_v); end
        fifo_full = 3'b001;
        tick; tick;
        exp_v = {F_FFS, 3'b001, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL b2b_cpe_full got=%b want=%b", obs, exp_v); end
        fifo_full = 3'b000;
        tick;
        parity_done = 1'b1;
        tick;
        exp_v = {F_DA, 3'b000, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL b2b_first_done got=%b want=%b", obs, exp_v); end
        parity_done = 1'b0; pkt_valid = 1'b1; data_in = 2'd2;
        tick;
        exp_v = {F_LFD, 3'b100, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL b2b_second_lfd got=%b want=%b", obs, exp_v); end
        pkt_valid = 1'b0;
        tick; tick; tick;
        exp_v = {F_CPE, 3'b100, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL b2b_second_cpe got=%b want=%b", obs, exp_v); end
        tick;
        exp_v = {F_DA, 3'b000, 2'b00}; compared++;
        if (obs !== exp_v) begin failed++; $display("FAIL b2b_second_done got=%b want=%b", obs, exp_v); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_full_stall;
        test_laf_paths;
        test_wait_timeout;
        test_wait_empty;
        test_addr_err;
        test_soft_reset;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/router_fsm_np.md
Name: router_fsm_np

Overview:
Parametrised next-generation router control FSM for a 1xN router, generalising the fixed 1x3 controller to N_PORTS destinations. It sits between the input register/parity block and the N output FIFOs. It decodes the header address, latches the destination, and sequences header/payload/parity loading with full-stall handling. New relative to the 1x3 controller: per-destination full/empty/soft-reset selection, invalid-address packet drop, and a bounded wait-till-empty timeout that drops the packet.

Parameters:
N_PORTS, 3, number of output FIFOs/destinations (legal 2..8)
ADDR_W, 2, header address field width; must satisfy 2**ADDR_W >= N_PORTS
WAIT_TIMEOUT, 32, max cycles spent in WAIT_TILL_EMPTY before dropping the packet (>=1)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous active-high reset
pkt_valid  in  1  packet valid from source
data_in  in  ADDR_W  header address bits (data byte [ADDR_W-1:0])
fifo_full  in  N_PORTS  per-FIFO full flags
fifo_empty  in  N_PORTS  per-FIFO empty flags
soft_reset  in  N_PORTS  per-FIFO soft reset (read timeout)
parity_done  in  1  parity byte loaded
low_pkt_valid  in  1  pkt_valid fell while stalled
detect_add  out  1  in DECODE_ADDRESS
lfd_state  out  1  in LOAD_FIRST_DATA
ld_state  out  1  in LOAD_DATA
full_state  out  1  in FIFO_FULL_STATE
laf_state  out  1  in LOAD_AFTER_FULL
rst_int_reg  out  1  in CHECK_PARITY_ERROR
drop_state  out  1  in DROP_PACKET
write_enb_reg  out  1  register-path write enable
busy  out  1  back-pressure to source
dest_sel  out  N_PORTS  one-hot latched destination, 0 when none
timeout_err  out  1  one-cycle pulse on wait timeout
addr_err  out  1  one-cycle pulse on invalid address

Behaviour:
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR, DROP_PACKET. Unreachable encodings -> DECODE_ADDRESS.
- Update priority: reset > soft_reset[dest] (only when state != DECODE_ADDRESS) > next state. soft_reset of non-selected ports is ignored.
- Reset / soft reset: state=DECODE_ADDRESS, dest cleared (dest_sel=0), wait counter=0, timeout_err=addr_err=0. detect_add=1; all other outputs 0.
- DECODE_ADDRESS: if pkt_valid and data_in>=N_PORTS -> DROP_PACKET, addr_err pulse next cycle. If pkt_valid and valid address, latch dest=data_in. Then go to LOAD_FIRST_DATA if fifo_empty[data_in], else WAIT_TILL_EMPTY with counter cleared. Otherwise stay.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
- LOAD_DATA: fifo_full[dest] -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay. Full takes precedence over pkt_valid low.
- LOAD_PARITY -> CHECK_PARITY_ERROR.
- FIFO_FULL_STATE: stay while fifo_full[dest]; else -> LOAD_AFTER_FULL.
- LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else LOAD_DATA.
- CHECK_PARITY_ERROR: fifo_full[dest] -> FIFO_FULL_STATE; else DECODE_ADDRESS, dest cleared.
- WAIT_TILL_EMPTY: examines only fifo_empty[dest]. If empty -> LOAD_FIRST_DATA. Else if counter==WAIT_TIMEOUT-1 -> DROP_PACKET with timeout_err pulse. Else counter+1. Counter width is clog2(WAIT_TIMEOUT+1) and never wraps.
- If empty and timeout occur in the same cycle, empty wins.
- DROP_PACKET: data is discarded (busy=0, write_enb_reg=0). Stay while pkt_valid=1. The first cycle with pkt_valid=0 -> DECODE_ADDRESS with dest cleared. The trailing parity byte arrives with pkt_valid=0 and is therefore ignored in DECODE_ADDRESS.
- Outputs are combinational decodes of the registered state, except timeout_err and addr_err, which are registered pulses.
- busy=1 in LOAD_FIRST_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR.
- write_enb_reg=1 in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL. It is 0 in WAIT_TILL_EMPTY and FIFO_FULL_STATE (no writes into a full or occupied FIFO).
- dest_sel is held from the latch cycle until return to DECODE_ADDRESS or DROP_PACKET exit.

Test Plan:
- N_PORTS=3: pkt_valid=1, data_in=2, fifo_empty=3'b111; 4 payload cycles, then pkt_valid=0 -> DECODE->LFD->LD x4->LP->CPE->DECODE. dest_sel=3'b100 throughout. busy=0 only in LD/DECODE.
- LOAD_DATA with fifo_full[1] asserting for 3 cycles, dest=1 -> FFS for 3 cycles, write_enb_reg=0 there. Then LAF, low_pkt_valid=1 -> LP. fifo_full[0] toggling during this must have no effect.
- data_in=1, fifo_empty=3'b101 (FIFO1 busy), WAIT_TIMEOUT=4, FIFO1 never empties -> exactly 4 cycles in WAIT, then DROP_PACKET. timeout_err high for 1 cycle. Return to DECODE on pkt_valid=0.
- Same setup, fifo_empty[1] rises on the 4th WAIT cycle -> LFD, no timeout_err.
- data_in=3 with N_PORTS=3, pkt_valid=1 -> DROP_PACKET, addr_err one pulse, busy=0, dest_sel=0.
- Mid-packet in LD with dest=0: soft_reset[2]=1 -> ignored. soft_reset[0]=1 -> DECODE next cycle. reset=1 in FFS -> DECODE, all pulses 0, dest_sel=0.
